instr_sequencer: RTL and testbench
==================================

// Module: instr_sequencer
// PURPOSE
//  Opcode issuer feeding the autoencoder control unit (CU). Fetches instruction
//  words from a synchronous-read instruction memory.
//  - Presents opcode + dst/src1/src2 operand addresses to CU, one instruction at a time.
//  - Stall input pauses issue; start/busy/done handshake with the training top.
//  - Drives NOP (4'b1111) to CU whenever no instruction is being issued.
// PARAMETERS
//  OP_WIDTH    4   opcode width; matches CU
//  ADDR_WIDTH  4   data-memory operand address width
//  PC_WIDTH    6   instruction-memory address width
//  PROG_LEN    64  program end: execution stops when pc reaches PROG_LEN
// PORTS
//  clk         in   1                     system clock
//  rst_n       in   1                     async active-low reset
//  start       in   1                     1-cycle pulse; begin execution at pc=0
//  stall       in   1                     hold current issue; pc frozen
//  imem_en     out  1                     instruction memory read enable
//  imem_addr   out  PC_WIDTH              instruction memory address
//  imem_rdata  in   OP_WIDTH+3*ADDR_WIDTH {opcode,dst,src1,src2}; valid 1 cycle after imem_en
//  opcode      out  OP_WIDTH              to CU; 4'b1111 when idle
//  dst_addr    out  ADDR_WIDTH            destination operand address
//  src1_addr   out  ADDR_WIDTH            source 1 operand address
//  src2_addr   out  ADDR_WIDTH            source 2 operand address
//  issue_valid out  1                     opcode/operand outputs hold a live instruction
//  busy        out  1                     high from the cycle after start until done
//  done        out  1                     1-cycle pulse at program end
// BEHAVIOUR
//  Reset (async, rst_n=0)
//   - state=IDLE, pc=0, opcode=4'hF, operands=0.
//   - issue_valid, busy, done, imem_en and imem_addr all 0.
//   - Asserting reset mid-program aborts immediately; no done pulse.
//  FSM states: IDLE, FETCH, LOAD, ISSUE, DONE
//   IDLE : start=1 -> FETCH, pc=0, busy=1. Otherwise stay.
//   FETCH: imem_en=1, imem_addr=pc -> LOAD.
//   LOAD : imem_rdata valid; decode on opcode field:
//          - 4'b1111 NOP : not issued; pc+1 -> FETCH, or DONE if pc+1==PROG_LEN.
//          - 4'b1110 HALT: not issued -> DONE.
//          - 4'b1001 LOOP: see CONFIGURATION.
//          - Any other   : register fields into outputs, issue_valid=1 -> ISSUE.
//   ISSUE: outputs stable for >=1 cycle.
//          - stall=1: hold everything, issue_valid stays 1.
//          - stall=0: opcode<=4'hF, issue_valid<=0, pc+1;
//            -> DONE if pc+1==PROG_LEN, else -> FETCH.
//   DONE : done=1 for one cycle, busy<=0 -> IDLE.
//  Throughput and timing
//   - 3 cycles per issued instruction with no stall.
//   - Registered opcode output; CU sees the new opcode the cycle after LOAD.
//   - start while busy=1 is ignored; start in DONE cycle ignored.
//  Boundary cases
//   - stall is sampled only in ISSUE.
//   - pc never wraps; the PROG_LEN check precedes the increment.
//   - Undefined opcodes 4'b1010-4'b1101 are issued unchanged; CU treats them as no-op.
// CONFIGURATION
//  Macro SEQ_LOOP_EN controls the hardware loop (single level, no nesting).
//  Defined, opcode 4'b1001 LOOP (never issued to CU; N=src2 field, target=src1 field):
//   - inactive: lc<=N-1; if N>1 then active<=1, pc<=target; else fall through pc+1.
//   - active:   if lc>1 then lc<=lc-1, pc<=target; else active<=0, pc+1.
//   - Net effect: loop body runs N times; N=0 or 1 runs it once.
//   - Reset and IDLE->FETCH clear active and lc.
//  Not defined:
//   - 4'b1001 is treated as NOP (skipped, pc+1); no lc/active registers are built.
// TESTING
//  T1 reset: rst_n=0 mid-ISSUE -> opcode=4'hF, issue_valid=0, busy=0, no done pulse.
//  T2 basic: prog {0000_0001_0010_0011, 1110_xxxx} + start ->
//     opcode=0000 dst=1 src1=2 src2=3, issue_valid=1 for 1 cycle;
//     done pulses 3 cycles later; issued count=1.
//  T3 stall: stall=1 for 5 cycles during ISSUE of 0010 ->
//     opcode held 6 cycles, imem_en=0 throughout, pc unchanged.
//  T4 NOP/end: prog of 63 NOPs then 0101 at addr 63, no HALT ->
//     only 0101 issued; done after pc reaches 64; busy then 0.
//  T5 loop (SEQ_LOOP_EN): {0000@0, 1001 src1=0 src2=3 @1, 1110@2} ->
//     0000 issued exactly 3 times, then done.
//     Without the macro: issued once, then done.
//  T6 start while busy: second start pulse during FETCH ->
//     ignored; single done pulse; pc sequence unaffected.

Source files
------------

// File: rtl/instr_sequencer.sv
`default_nettype none
// instr_sequencer: fetches {opcode,dst,src1,src2} words from a sync-read imem and issues them to the CU.
// Optional single-level hardware loop (opcode 4'b1001) is built only when SEQ_LOOP_EN is defined.
module instr_sequencer #(
  parameter int OP_WIDTH   = 4,
  parameter int ADDR_WIDTH = 4,
  parameter int PC_WIDTH   = 6,
  parameter int PROG_LEN   = 64
) (
  input  logic                             clk,
  input  logic                             rst_n,
  input  logic                             start,
  input  logic                             stall,
  output logic                             imem_en,
  output logic [PC_WIDTH-1:0]              imem_addr,
  input  logic [OP_WIDTH+3*ADDR_WIDTH-1:0] imem_rdata,
  output logic [OP_WIDTH-1:0]              opcode,
  output logic [ADDR_WIDTH-1:0]            dst_addr,
  output logic [ADDR_WIDTH-1:0]            src1_addr,
  output logic [ADDR_WIDTH-1:0]            src2_addr,
  output logic                             issue_valid,
  output logic                             busy,
  output logic                             done
);
  localparam int IW = OP_WIDTH + 3*ADDR_WIDTH;

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_FETCH = 3'd1;
  localparam logic [2:0] S_LOAD  = 3'd2;
  localparam logic [2:0] S_ISSUE = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [OP_WIDTH-1:0] OP_NOP  = OP_WIDTH'(4'hF);
  localparam logic [OP_WIDTH-1:0] OP_HALT = OP_WIDTH'(4'hE);
  localparam logic [OP_WIDTH-1:0] OP_LOOP = OP_WIDTH'(4'h9);
  localparam logic [PC_WIDTH:0]   END_PC  = (PC_WIDTH+1)'(PROG_LEN);

  logic [2:0]            state, state_d, state_adv;
  logic [PC_WIDTH-1:0]   pc, pc_d, pc_adv;
  logic [PC_WIDTH:0]     pc_inc;
  logic                  at_end;
  logic                  take_issue;
  logic [OP_WIDTH-1:0]   f_op;
  logic [ADDR_WIDTH-1:0] f_dst, f_src1, f_src2;

  assign f_op   = imem_rdata[IW-1 -: OP_WIDTH];
  assign f_dst  = imem_rdata[3*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign f_src1 = imem_rdata[2*ADDR_WIDTH-1 -: ADDR_WIDTH];
  assign f_src2 = imem_rdata[ADDR_WIDTH-1:0];

  // End check uses a widened pc so the program end is detected before pc could wrap.
  assign pc_inc    = {1'b0, pc} + (PC_WIDTH+1)'(1);
  assign at_end    = (pc_inc == END_PC);
  assign state_adv = at_end ? S_DONE : S_FETCH;
  assign pc_adv    = at_end ? pc : pc_inc[PC_WIDTH-1:0];

  assign imem_en   = (state == S_FETCH);
  assign imem_addr = pc;
  assign done      = (state == S_DONE);

`ifdef SEQ_LOOP_EN
  logic                  loop_active, loop_active_d;
  logic [ADDR_WIDTH-1:0] lc, lc_d;
`endif

  always_comb begin
    state_d    = state;
    pc_d       = pc;
    take_issue = 1'b0;
`ifdef SEQ_LOOP_EN
    loop_active_d = loop_active;
    lc_d          = lc;
`endif
    case (state)
      S_IDLE: begin
        if (start) begin
          state_d = S_FETCH;
          pc_d    = '0;
`ifdef SEQ_LOOP_EN
          loop_active_d = 1'b0;
          lc_d          = '0;
`endif
        end
      end
      S_FETCH: state_d = S_LOAD;
      S_LOAD: begin
        state_d = state_adv;
        pc_d    = pc_adv;
        if (f_op == OP_HALT) begin
          state_d = S_DONE;
          pc_d    = pc;
        end
`ifdef SEQ_LOOP_EN
        else if (f_op == OP_LOOP) begin
          if (!loop_active) begin
            lc_d = f_src2 - ADDR_WIDTH'(1);
            if (f_src2 > ADDR_WIDTH'(1)) begin
              loop_active_d = 1'b1;
              pc_d          = PC_WIDTH'(f_src1);
              state_d       = S_FETCH;
            end
          end else if (lc > ADDR_WIDTH'(1)) begin
            lc_d    = lc - ADDR_WIDTH'(1);
            pc_d    = PC_WIDTH'(f_src1);
            state_d = S_FETCH;
          end else begin
            loop_active_d = 1'b0;
          end
        end
`endif
        else if (f_op != OP_NOP && f_op != OP_LOOP) begin
          take_issue = 1'b1;
          state_d    = S_ISSUE;
          pc_d       = pc;
        end
      end
      S_ISSUE: begin
        if (!stall) begin
          state_d = state_adv;
          pc_d    = pc_adv;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      pc          <= '0;
      opcode      <= OP_NOP;
      dst_addr    <= '0;
      src1_addr   <= '0;
      src2_addr   <= '0;
      issue_valid <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state <= state_d;
      pc    <= pc_d;
      if (state == S_IDLE && start) begin
        busy <= 1'b1;
      end else if (state == S_DONE) begin
        busy <= 1'b0;
      end
      if (take_issue) begin
        opcode      <= f_op;
        dst_addr    <= f_dst;
        src1_addr   <= f_src1;
        src2_addr   <= f_src2;
        issue_valid <= 1'b1;
      end else if (state == S_ISSUE && !stall) begin
        opcode      <= OP_NOP;
        issue_valid <= 1'b0;
      end
    end
  end

`ifdef SEQ_LOOP_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      loop_active <= 1'b0;
      lc          <= '0;
    end else begin
      loop_active <= loop_active_d;
      lc          <= lc_d;
    end
  end
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_sequencer.sv
`default_nettype none
// tb_instr_sequencer: directed and randomized programs checked against a program-level interpreter model.
module tb_instr_sequencer;
  logic        clk = 1'b0;
  logic        rst_n, start, stall;
  logic        imem_en;
  logic [5:0]  imem_addr;
  logic [15:0] imem_rdata = 16'h0;
  logic [3:0]  opcode, dst_addr, src1_addr, src2_addr;
  logic        issue_valid, busy, done;

  logic [15:0] mem [64];
  logic [15:0] exp_q[$];
  logic [15:0] got_q[$];
  int exp_cost;
  int r_done_cyc, r_done_cnt, r_stall_hits, r_iv_cycles;
  int checks = 0;
  int errors = 0;

  instr_sequencer dut (
    .clk(clk), .rst_n(rst_n), .start(start), .stall(stall),
    .imem_en(imem_en), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .opcode(opcode), .dst_addr(dst_addr), .src1_addr(src1_addr), .src2_addr(src2_addr),
    .issue_valid(issue_valid), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  always @(posedge clk) if (imem_en) imem_rdata <= mem[imem_addr];

  task automatic clear_mem();
    for (int i = 0; i < 64; i++) mem[i] = 16'hF000;
  endtask

  // Interprets the program: issued words in order and cycle cost (2 per fetched word, +1 per issued word).
  task automatic model_program();
    int pc, nxt;
    bit active;
    int lc, n, tgt;
    logic [15:0] w;
    exp_q.delete();
    exp_cost = 0; pc = 0; active = 0; lc = 0;
    for (int steps = 0; steps < 5000; steps++) begin
      w = mem[pc[5:0]];
      exp_cost += 2;
      if (w[15:12] == 4'hE) break;
      nxt = pc + 1;
      if (w[15:12] == 4'h9) begin
`ifdef SEQ_LOOP_EN
        n = int'(w[3:0]);
        tgt = int'(w[7:4]);
        if (!active) begin
          if (n > 1) begin active = 1; lc = n - 1; nxt = tgt; end
        end else if (lc > 1) begin
          lc--; nxt = tgt;
        end else begin
          active = 0;
        end
`endif
      end else if (w[15:12] != 4'hF) begin
        exp_q.push_back(w);
        exp_cost++;
      end
      if (nxt == 64) break;
      pc = nxt;
    end
  endtask

  // extra_start: cycle to pulse a second start (0 = none, -1 = the expected DONE cycle)
  task automatic run_prog(input int stall_pct, input int extra_start, input string name);
    logic prev_iv;
    bit busy_bad, busy_after_bad, op_bad;
    int start_at, n;
    model_program();
    start_at = (extra_start < 0) ? exp_cost + 1 : extra_start;
    got_q.delete();
    r_done_cyc = -1; r_done_cnt = 0; r_stall_hits = 0; r_iv_cycles = 0;
    prev_iv = 1'b0; busy_bad = 0; busy_after_bad = 0; op_bad = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int cyc = 1; cyc <= 6000; cyc++) begin
      if (issue_valid === 1'b1 && !prev_iv) got_q.push_back({opcode, dst_addr, src1_addr, src2_addr});
      if (issue_valid === 1'b1) r_iv_cycles++;
      if (issue_valid !== 1'b1 && opcode !== 4'hF) op_bad = 1;
      if (issue_valid === 1'b1 && imem_en !== 1'b0) op_bad = 1;
      if (done === 1'b1) begin
        r_done_cnt++;
        if (r_done_cyc < 0) r_done_cyc = cyc;
      end else if (r_done_cyc >= 0 && busy !== 1'b0) begin
        busy_after_bad = 1;
      end
      if (r_done_cyc < 0 && busy !== 1'b1) busy_bad = 1;
      prev_iv = (issue_valid === 1'b1);
      start = (cyc == start_at);
      stall = ($urandom_range(99) < stall_pct);
      if (issue_valid === 1'b1 && stall) r_stall_hits++;
      if (r_done_cyc >= 0 && cyc >= r_done_cyc + 4) break;
      @(negedge clk);
    end
    start = 1'b0; stall = 1'b0;

    checks++;
    if (r_done_cyc < 0) begin
      errors++; $display("FAIL %s done_timeout: done not seen, required within budget", name);
    end else if (r_done_cyc != exp_cost + 1 + r_stall_hits) begin
      errors++; $display("FAIL %s done_cycle: got %0d required %0d", name, r_done_cyc, exp_cost + 1 + r_stall_hits);
    end
    checks++;
    if (r_done_cnt != 1) begin errors++; $display("FAIL %s done_count: got %0d required 1", name, r_done_cnt); end
    checks++;
    if (got_q.size() != exp_q.size()) begin
      errors++; $display("FAIL %s issue_count: got %0d required %0d", name, got_q.size(), exp_q.size());
    end
    n = (got_q.size() < exp_q.size()) ? got_q.size() : exp_q.size();
    for (int i = 0; i < n; i++) begin
      checks++;
      if (got_q[i] !== exp_q[i]) begin
        errors++; $display("FAIL %s issue[%0d]: got %h required %h", name, i, got_q[i], exp_q[i]);
      end
    end
    checks++;
    if (busy_bad) begin errors++; $display("FAIL %s busy_during_run: got 0 required 1", name); end
    checks++;
    if (busy_after_bad) begin errors++; $display("FAIL %s busy_after_done: got 1 required 0", name); end
    checks++;
    if (op_bad) begin errors++; $display("FAIL %s idle_outputs: got non-NOP or imem_en during issue, required NOP/0", name); end
  endtask

  task automatic test_reset();
    logic [26:0] got;
    bit seen;
    got = {opcode, dst_addr, src1_addr, src2_addr, issue_valid, busy, done, imem_en, imem_addr};
    checks++;
    if (got !== {4'hF, 12'h000, 4'b0000, 6'd0}) begin
      errors++; $display("FAIL reset_state: got %h required %h", got, {4'hF, 12'h000, 4'b0000, 6'd0});
    end
    @(negedge clk); rst_n = 1'b1;
    clear_mem(); mem[0] = 16'h3456; mem[1] = 16'hE000;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0; stall = 1'b1;
    for (int i = 0; i < 10 && issue_valid !== 1'b1; i++) @(negedge clk);
    checks++;
    if (issue_valid !== 1'b1) begin errors++; $display("FAIL reset_reach_issue: got %b required 1", issue_valid); end
    #2 rst_n = 1'b0;
    #1;
    got = {opcode, dst_addr, src1_addr, src2_addr, issue_valid, busy, done, imem_en, imem_addr};
    checks++;
    if (got !== {4'hF, 12'h000, 4'b0000, 6'd0}) begin
      errors++; $display("FAIL reset_mid_issue: got %h required %h", got, {4'hF, 12'h000, 4'b0000, 6'd0});
    end
    @(negedge clk); rst_n = 1'b1; stall = 1'b0;
    seen = 0;
    repeat (12) begin @(negedge clk); if (done !== 1'b0 || busy !== 1'b0) seen = 1; end
    checks++;
    if (seen) begin errors++; $display("FAIL reset_no_done: got done/busy activity required none"); end
  endtask

  task automatic test_basic();
    clear_mem(); mem[0] = 16'h0123; mem[1] = 16'hE5A5;
    run_prog(0, 0, "basic");
    checks++;
    if (got_q.size() != 1 || got_q[0] !== 16'h0123) begin
      errors++; $display("FAIL basic_word: got %0d words first %h required 1 word 0123", got_q.size(), (got_q.size() > 0) ? got_q[0] : 16'hxxxx);
    end
    checks++;
    if (r_iv_cycles != 1) begin errors++; $display("FAIL basic_valid_len: got %0d required 1", r_iv_cycles); end
    checks++;
    if (r_done_cyc != 6) begin errors++; $display("FAIL basic_done_cycle: got %0d required 6", r_done_cyc); end
  endtask

  task automatic test_stall();
    int held;
    bit en_bad, fin;
    clear_mem(); mem[0] = 16'h2345; mem[1] = 16'hE000;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < 10 && issue_valid !== 1'b1; i++) @(negedge clk);
    checks++;
    if (issue_valid !== 1'b1) begin errors++; $display("FAIL stall_issue_timeout: got %b required 1", issue_valid); end
    held = (issue_valid === 1'b1 && opcode === 4'h2) ? 1 : 0;
    en_bad = 0;
    stall = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      @(negedge clk);
      if (issue_valid === 1'b1 && opcode === 4'h2 && dst_addr === 4'h3) held++;
      if (imem_en !== 1'b0) en_bad = 1;
      if (i == 5) stall = 1'b0;
    end
    checks++;
    if (held != 6) begin errors++; $display("FAIL stall_hold_cycles: got %0d required 6", held); end
    checks++;
    if (en_bad) begin errors++; $display("FAIL stall_imem_en: got 1 required 0"); end
    @(negedge clk);
    checks++;
    if ({issue_valid, opcode, imem_en, imem_addr} !== {1'b0, 4'hF, 1'b1, 6'd1}) begin
      errors++; $display("FAIL stall_release: got iv=%b op=%h en=%b addr=%0d required iv=0 op=f en=1 addr=1",
                         issue_valid, opcode, imem_en, imem_addr);
    end
    fin = 0;
    for (int i = 0; i < 10 && !fin; i++) begin @(negedge clk); if (done === 1'b1) fin = 1; end
    checks++;
    if (!fin) begin errors++; $display("FAIL stall_done_timeout: done not seen, required within 10 cycles"); end
    repeat (3) @(negedge clk);
  endtask

  task automatic test_nop_end();
    clear_mem(); mem[63] = 16'h5ABC;
    run_prog(0, 0, "nop_end");
    checks++;
    if (got_q.size() != 1 || got_q[0][15:12] !== 4'h5) begin
      errors++; $display("FAIL nop_end_issue: got %0d words required 1 word with opcode 5", got_q.size());
    end
    checks++;
    if (r_done_cyc != 63*2 + 3 + 1) begin errors++; $display("FAIL nop_end_done_cycle: got %0d required %0d", r_done_cyc, 63*2 + 4); end
  endtask

  task automatic test_loop();
    int exp_n;
`ifdef SEQ_LOOP_EN
    exp_n = 3;
`else
    exp_n = 1;
`endif
    clear_mem(); mem[0] = 16'h0123; mem[1] = 16'h9003; mem[2] = 16'hE000;
    run_prog(0, 0, "loop");
    checks++;
    if (got_q.size() != exp_n) begin errors++; $display("FAIL loop_body_count: got %0d required %0d", got_q.size(), exp_n); end
  endtask

  task automatic test_start_busy();
    clear_mem(); mem[0] = 16'h4567; mem[1] = 16'h7ABC; mem[2] = 16'hE000;
    run_prog(0, 1, "start_in_fetch");
    run_prog(0, -1, "start_in_done");
  endtask

  task automatic test_random();
    int len, r;
    bit loop_used;
    logic [3:0] op;
    for (int it = 0; it < 30; it++) begin
      clear_mem();
      len = $urandom_range(1, 12);
      loop_used = 0;
      for (int i = 0; i < len; i++) begin
        r = $urandom_range(0, 19);
        if (r < 2) begin
          mem[i] = {4'hF, 12'($urandom)};
        end else if (r == 2) begin
          mem[i] = {4'hE, 12'($urandom)};
        end else if (r < 6 && i > 0 && !loop_used) begin
          loop_used = 1;
          mem[i] = {4'h9, 4'($urandom), 4'($urandom_range(0, i - 1)), 4'($urandom_range(0, 5))};
        end else begin
          r = $urandom_range(0, 12);
          op = (r < 9) ? 4'(r) : 4'(r + 1);
          mem[i] = {op, 12'($urandom)};
        end
      end
      if ($urandom_range(0, 3) != 0) mem[len] = 16'hE000;
      run_prog((it % 2 == 1) ? 30 : 0, 0, "random");
    end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; stall = 1'b0;
    clear_mem();
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_stall();
    test_nop_end();
    test_loop();
    test_start_busy();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
`default_nettype wire
